// File: rtl/bram_sdp_lanes.sv
// Simple-dual-port block RAM with per-lane write enables, 1..3 cycle read latency and a sequential clear engine.
// Optional build macro BRAM_COLLISION_BYPASS_EN: per-lane write-first forwarding on same-address read/write.
module bram_sdp_lanes #(
  parameter int NUM_LANES      = 4,
  parameter int LANE_WIDTH     = 8,
  parameter int RAM_DEPTH      = 1024,
  parameter int READ_LATENCY   = 2,
  parameter int CLEAR_ON_RESET = 1,
  localparam int W  = NUM_LANES * LANE_WIDTH,
  localparam int AW = $clog2(RAM_DEPTH)
) (
  input  logic                 clka,
  input  logic                 rstb,
  input  logic [AW-1:0]        addra,
  input  logic [W-1:0]         dina,
  input  logic [NUM_LANES-1:0] wea,
  input  logic [AW-1:0]        addrb,
  input  logic                 enb,
  input  logic                 clear_req,
  output logic [W-1:0]         doutb,
  output logic                 doutb_valid,
  output logic                 busy
);

  if (READ_LATENCY < 1 || READ_LATENCY > 3) begin : g_bad_latency
    $error("bram_sdp_lanes: READ_LATENCY must be in 1..3");
  end
  if (RAM_DEPTH < 2) begin : g_bad_depth
    $error("bram_sdp_lanes: RAM_DEPTH must be at least 2");
  end

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  localparam state_t        RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
  localparam logic [AW-1:0] LAST_ADDR = AW'(RAM_DEPTH - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;

  always_ff @(posedge clka) begin
    if (rstb) begin
      state_q    <= RST_STATE;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d    = CLEAR;
          clr_addr_d = '0;
        end
      end
      CLEAR: begin
        if (clr_addr_q == LAST_ADDR) begin
          state_d    = IDLE;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + AW'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        clr_addr_d = '0;
      end
    endcase
  end

  assign busy = (state_q == CLEAR);

  // Nothing touches the array while reset is held; memory contents survive reset.
  logic clearing, wr_ok, rd_acc;
  assign clearing = busy & ~rstb;
  assign wr_ok    = ~busy & ~rstb;
  assign rd_acc   = enb & ~busy & ~rstb;

  logic [W-1:0] mem [RAM_DEPTH];

  always_ff @(posedge clka) begin
    if (clearing) begin
      mem[clr_addr_q] <= '0;
    end else if (wr_ok) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        if (wea[k]) mem[addra][k*LANE_WIDTH +: LANE_WIDTH] <= dina[k*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

  logic [W-1:0] rd_word;

`ifdef BRAM_COLLISION_BYPASS_EN
  // Forward freshly written lanes ahead of the first read register so latency is unchanged.
  always_comb begin
    rd_word = mem[addrb];
    if (wr_ok && (addra == addrb)) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        if (wea[k]) rd_word[k*LANE_WIDTH +: LANE_WIDTH] = dina[k*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end
`else
  assign rd_word = mem[addrb];
`endif

  logic [READ_LATENCY-1:0] vld_q, vld_d;

  always_comb begin
    vld_d    = vld_q << 1;
    vld_d[0] = rd_acc;
  end

  always_ff @(posedge clka) begin
    if (rstb) vld_q <= '0;
    else      vld_q <= vld_d;
  end

  assign doutb_valid = vld_q[READ_LATENCY-1];

  if (READ_LATENCY == 1) begin : g_lat1
    always_ff @(posedge clka) begin
      if (rstb)        doutb <= '0;
      else if (rd_acc) doutb <= rd_word;
    end
  end else begin : g_latn
    logic [W-1:0] pipe_q [READ_LATENCY-1];

    always_ff @(posedge clka) begin
      pipe_q[0] <= rd_word;
      for (int i = 1; i < READ_LATENCY - 1; i++) pipe_q[i] <= pipe_q[i-1];
    end

    // The output stage loads only on an arriving valid so doutb holds between results.
    always_ff @(posedge clka) begin
      if (rstb)                         doutb <= '0;
      else if (vld_q[READ_LATENCY-2])   doutb <= pipe_q[READ_LATENCY-2];
    end
  end

endmodule

// File: tb/tb_bram_sdp_lanes.sv
// Bench for bram_sdp_lanes: three instances (latency 2/3/1, auto-clear on/off/on) share one stimulus
// stream and are checked every cycle against a behavioural array/queue model, plus literal pins.
module tb_bram_sdp_lanes;
  localparam int NL = 4;
  localparam int LW = 8;
  localparam int W  = NL * LW;
  localparam int D  = 16;
  localparam int AW = 4;
  localparam int NI = 3;
  localparam logic [NI-1:0][1:0] LATP = {2'd1, 2'd3, 2'd2};
  localparam logic [NI-1:0]      CORP = 3'b101;

  logic          clk = 1'b0;
  logic          rstb = 1'b1;
  logic [AW-1:0] addra = '0, addrb = '0;
  logic [W-1:0]  dina = '0;
  logic [NL-1:0] wea = '0;
  logic          enb = 1'b0, clear_req = 1'b0;
  logic [W-1:0]  dout_w [NI];
  logic [NI-1:0] valid_w, busy_w;

  always #5 clk = ~clk;

  bram_sdp_lanes #(.NUM_LANES(NL), .LANE_WIDTH(LW), .RAM_DEPTH(D), .READ_LATENCY(2), .CLEAR_ON_RESET(1)) u0 (
    .clka(clk), .rstb(rstb), .addra(addra), .dina(dina), .wea(wea), .addrb(addrb), .enb(enb),
    .clear_req(clear_req), .doutb(dout_w[0]), .doutb_valid(valid_w[0]), .busy(busy_w[0]));
  bram_sdp_lanes #(.NUM_LANES(NL), .LANE_WIDTH(LW), .RAM_DEPTH(D), .READ_LATENCY(3), .CLEAR_ON_RESET(0)) u1 (
    .clka(clk), .rstb(rstb), .addra(addra), .dina(dina), .wea(wea), .addrb(addrb), .enb(enb),
    .clear_req(clear_req), .doutb(dout_w[1]), .doutb_valid(valid_w[1]), .busy(busy_w[1]));
  bram_sdp_lanes #(.NUM_LANES(NL), .LANE_WIDTH(LW), .RAM_DEPTH(D), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) u2 (
    .clka(clk), .rstb(rstb), .addra(addra), .dina(dina), .wea(wea), .addrb(addrb), .enb(enb),
    .clear_req(clear_req), .doutb(dout_w[2]), .doutb_valid(valid_w[2]), .busy(busy_w[2]));

  // ---------------- behavioural model ----------------
  logic [W-1:0] mem_m   [NI][D];
  logic [W-1:0] known_m [NI][D];
  int           clear_left [NI];
  logic [W-1:0] exp_q [NI][$];
  logic [W-1:0] msk_q [NI][$];
  longint       due_q [NI][$];
  logic [W-1:0] dout_m [NI];
  logic [W-1:0] dmsk_m [NI];
  logic         valid_m [NI];
  longint       cyc = 0;
  int           checks = 0, failures = 0;

  function automatic logic [W-1:0] lane_mask(input logic [NL-1:0] we);
    logic [W-1:0] m = '0;
    for (int k = 0; k < NL; k++) if (we[k]) m[k*LW +: LW] = '1;
    return m;
  endfunction

  task automatic check(input string name, input int inst, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s inst%0d cycle=%0d got=%h expected=%h", name, inst, cyc, got, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      clear_left[i] = 0;
      dout_m[i] = '0;
      dmsk_m[i] = '1;
      valid_m[i] = 1'b0;
      for (int a = 0; a < D; a++) begin
        mem_m[i][a] = '0;
        known_m[i][a] = '0;
      end
    end
  end

  always @(posedge clk) begin
    logic [W-1:0] rd, rm, lm;
    logic         bz;
    cyc++;
    for (int i = 0; i < NI; i++) begin
      if (rstb) begin
        clear_left[i] = CORP[i] ? D : 0;
        exp_q[i].delete();
        msk_q[i].delete();
        due_q[i].delete();
        dout_m[i] = '0;
        dmsk_m[i] = '1;
        valid_m[i] = 1'b0;
      end else begin
        bz = (clear_left[i] > 0);
        valid_m[i] = 1'b0;
        lm = lane_mask(wea);
        if (enb && !bz) begin
          rd = mem_m[i][addrb];
          rm = known_m[i][addrb];
`ifdef BRAM_COLLISION_BYPASS_EN
          if (addra == addrb) begin
            rd = (rd & ~lm) | (dina & lm);
            rm = rm | lm;
          end
`endif
          exp_q[i].push_back(rd);
          msk_q[i].push_back(rm);
          due_q[i].push_back(cyc + longint'(LATP[i]) - 1);
        end
        if (bz) begin
          mem_m[i][D - clear_left[i]] = '0;
          known_m[i][D - clear_left[i]] = '1;
          clear_left[i]--;
        end else begin
          mem_m[i][addra] = (mem_m[i][addra] & ~lm) | (dina & lm);
          known_m[i][addra] = known_m[i][addra] | lm;
          if (clear_req) clear_left[i] = D;
        end
        if (due_q[i].size() > 0 && due_q[i][0] == cyc) begin
          void'(due_q[i].pop_front());
          dout_m[i] = exp_q[i].pop_front();
          dmsk_m[i] = msk_q[i].pop_front();
          valid_m[i] = 1'b1;
        end
      end
    end
    #1;
    for (int i = 0; i < NI; i++) begin
      check("busy", i, W'(busy_w[i]), W'(clear_left[i] > 0));
      check("doutb_valid", i, W'(valid_w[i]), W'(valid_m[i]));
      check("doutb", i, dout_w[i] & dmsk_m[i], dout_m[i] & dmsk_m[i]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [AW-1:0] wa, input logic [W-1:0] d, input logic [NL-1:0] we,
                       input logic [AW-1:0] ra, input logic re, input logic cr);
    @(negedge clk);
    addra = wa; dina = d; wea = we; addrb = ra; enb = re; clear_req = cr;
  endtask

  task automatic idle();
    drive('0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  // One accepted read (optionally with a same-cycle write), then pin each instance at its own latency.
  task automatic xact(input string name, input logic [AW-1:0] wa, input logic [W-1:0] d, input logic [NL-1:0] we,
                      input logic [AW-1:0] ra, input logic [W-1:0] exp_c1, input logic [W-1:0] exp_c0);
    drive(wa, d, we, ra, 1'b1, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      idle();
      for (int i = 0; i < NI; i++) begin
        if (int'(LATP[i]) == k) begin
          check({name, "_valid"}, i, W'(valid_w[i]), W'(1));
          check({name, "_data"}, i, dout_w[i], CORP[i] ? exp_c1 : exp_c0);
        end
      end
    end
  endtask

  task automatic release_and_count(input logic cr, input int exp_c1, input int exp_c0);
    int cnt [NI];
    @(negedge clk);
    rstb = 1'b0; clear_req = cr; enb = 1'b0; wea = '0;
    for (int i = 0; i < NI; i++) cnt[i] = int'(busy_w[i]);
    repeat (40) begin
      idle();
      for (int i = 0; i < NI; i++) cnt[i] += int'(busy_w[i]);
    end
    for (int i = 0; i < NI; i++) check("busy_cycles", i, W'(cnt[i]), W'(CORP[i] ? exp_c1 : exp_c0));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_w != '0 && n < 60) begin
      idle();
      n++;
    end
    check("wait_idle_timeout", 0, W'(busy_w), W'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] coll_exp;
    repeat (3) idle();
    for (int i = 0; i < NI; i++) begin
      check("reset_busy", i, W'(busy_w[i]), W'(CORP[i]));
      check("reset_valid", i, W'(valid_w[i]), W'(0));
      check("reset_dout", i, dout_w[i], '0);
    end

    // Auto-clear on u0/u2; u1 gets a request in the same cycle, which u0/u2 ignore while clearing.
    release_and_count(1'b1, 16, 16);
    xact("clr_read5", '0, '0, '0, 4'd5, 32'h0, 32'h0);

    drive(4'd3, 32'hAABBCCDD, 4'b1111, '0, 1'b0, 1'b0);
    drive(4'd3, 32'h11223344, 4'b0101, '0, 1'b0, 1'b0);
    xact("lane_write", '0, '0, '0, 4'd3, 32'hAA22CC44, 32'hAA22CC44);

`ifdef BRAM_COLLISION_BYPASS_EN
    coll_exp = 32'h0000FFFF;
`else
    coll_exp = 32'h00000000;
`endif
    xact("collision", 4'd9, 32'hFFFFFFFF, 4'b0011, 4'd9, coll_exp, coll_exp);

    for (int a = 0; a < 8; a++) drive(AW'(a), W'(a) * 32'h01010101, 4'b1111, '0, 1'b0, 1'b0);
    for (int a = 0; a < 8; a++) drive('0, '0, '0, AW'(a), 1'b1, 1'b0);
    repeat (4) idle();

    // Random traffic with occasional clear requests and resets.
    for (int n = 0; n < 500; n++) begin
      drive(AW'($urandom_range(0, D-1)), W'($urandom),
            ($urandom_range(0, 1) == 1) ? NL'($urandom_range(0, 15)) : '0,
            AW'($urandom_range(0, D-1)), ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 59) == 0));
      rstb = ($urandom_range(0, 119) == 0);
    end
    rstb = 1'b0;
    idle();
    wait_idle();

    // Reset in the middle of a clear, with clr_addr at 7.
    for (int a = 0; a < D; a++) drive(AW'(a), 32'hC0DE0000 | W'(a), 4'b1111, '0, 1'b0, 1'b0);
    drive('0, '0, '0, '0, 1'b0, 1'b1);
    repeat (7) idle();
    @(negedge clk);
    rstb = 1'b1; clear_req = 1'b0;
    release_and_count(1'b0, 16, 0);
    wait_idle();
    xact("kept_after_abort", '0, '0, '0, 4'd10, 32'h0, 32'hC0DE000A);
    xact("cleared_before_abort", '0, '0, '0, 4'd3, 32'h0, 32'h0);
    for (int a = 0; a < D; a++) drive('0, '0, '0, AW'(a), 1'b1, 1'b0);
    repeat (5) idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
